// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline constants: default stage widths, per-boundary payload widths
// and the bit order used when packing killable control bits.
package cpu_pipe_pkg;

    localparam int DEFAULT_DATA_W = 64;
    localparam int DEFAULT_CTRL_W = 8;
    localparam int DEFAULT_CNT_W  = 16;

    // Per-boundary widths; data carries PC plus the operands/immediates live at that point.
    localparam int IFID_CTRL_W  = 1;
    localparam int IFID_DATA_W  = 96;
    localparam int IDEX_CTRL_W  = 8;
    localparam int IDEX_DATA_W  = 256;
    localparam int EXMEM_CTRL_W = 5;
    localparam int EXMEM_DATA_W = 197;
    localparam int MEMWB_CTRL_W = 2;
    localparam int MEMWB_DATA_W = 133;

    // Packing order of control bits, MSB first; reg_write sits in bit 0.
    typedef struct packed {
        logic       branch;
        logic [1:0] alu_op;
        logic       alu_src;
        logic       mem_to_reg;
        logic       mem_write;
        logic       mem_read;
        logic       reg_write;
    } ctrl_t;

    localparam int CTRL_REG_WRITE  = 0;
    localparam int CTRL_MEM_READ   = 1;
    localparam int CTRL_MEM_WRITE  = 2;
    localparam int CTRL_MEM_TO_REG = 3;
    localparam int CTRL_ALU_SRC    = 4;
    localparam int CTRL_ALU_OP_LSB = 5;
    localparam int CTRL_BRANCH     = 7;

endpackage

// File: rtl/pipe_skid_buf.sv
// Second (skid) entry of a pipeline stage: catches one item while the main
// register is stalled, so the upstream ready can be registered.
module pipe_skid_buf
    import cpu_pipe_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CTRL_W = DEFAULT_CTRL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Push wins over pop so a simultaneous refill keeps the entry occupied.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (push_i) begin
            valid_d = 1'b1;
            ctrl_d  = ctrl_i;
            data_d  = data_i;
        end else if (pop_i) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable handshaked pipeline stage register with killable control, flush and
// a bubble counter. Define PIPE_STAGE_SKID_EN to add a skid entry (registered in_ready).
module pipe_stage_reg
    import cpu_pipe_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CTRL_W = DEFAULT_CTRL_W,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic              out_flushed,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // Handshake: an item moves on a rising edge where valid & ready are both high
    // on that side; valid never depends on ready, and flush vetoes the input transfer.
    logic              main_valid_q, main_valid_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic              flushed_q, flushed_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

    logic              accept;
    logic              advance;
    logic              skid_valid;
    logic              load_valid;
    logic [CTRL_W-1:0] load_ctrl;
    logic [DATA_W-1:0] load_data;

    assign accept  = in_valid & in_ready & ~flush;
    assign advance = ~main_valid_q | out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              skid_push;
    logic              skid_pop;

    assign in_ready  = ~skid_valid;
    assign skid_push = accept & main_valid_q & ~out_ready;
    assign skid_pop  = skid_valid & advance;

    pipe_skid_buf #(
        .DATA_W(DATA_W),
        .CTRL_W(CTRL_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .push_i  (skid_push),
        .pop_i   (skid_pop),
        .ctrl_i  (in_ctrl),
        .data_i  (in_data),
        .valid_o (skid_valid),
        .ctrl_o  (skid_ctrl),
        .data_o  (skid_data)
    );

    // The skid entry is older than anything on the input, so it refills main first.
    always_comb begin
        load_valid = accept;
        load_ctrl  = in_ctrl;
        load_data  = in_data;
        if (skid_valid) begin
            load_valid = 1'b1;
            load_ctrl  = skid_ctrl;
            load_data  = skid_data;
        end
    end
`else
    assign skid_valid = 1'b0;
    assign in_ready   = ~main_valid_q | out_ready;
    assign load_valid = accept;
    assign load_ctrl  = in_ctrl;
    assign load_data  = in_data;
`endif

    always_comb begin
        main_valid_d = main_valid_q;
        main_ctrl_d  = main_ctrl_q;
        main_data_d  = main_data_q;
        flushed_d    = flushed_q;
        bubble_cnt_d = bubble_cnt_q;
        if (out_ready && !main_valid_q && bubble_cnt_q != {CNT_W{1'b1}}) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
        if (flush) begin
            main_valid_d = 1'b0;
            main_ctrl_d  = '0;
            flushed_d    = 1'b1;
        end else if (advance) begin
            main_valid_d = load_valid;
            if (load_valid) begin
                main_ctrl_d = load_ctrl;
                main_data_d = load_data;
                flushed_d   = 1'b0;
            end else begin
                main_ctrl_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_ctrl_q  <= '0;
            main_data_q  <= '0;
            flushed_q    <= 1'b0;
            bubble_cnt_q <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_ctrl_q  <= main_ctrl_d;
            main_data_q  <= main_data_d;
            flushed_q    <= flushed_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign out_valid   = main_valid_q;
    assign out_ctrl    = main_ctrl_q & {CTRL_W{main_valid_q}};
    assign out_data    = main_data_q;
    assign out_flushed = flushed_q;
    assign occupancy   = {1'b0, main_valid_q} + {1'b0, skid_valid};
    assign bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus random traffic
// against a queue-based reference model of the stage.
module tb_pipe_stage_reg;

    localparam int DATA_W = 64;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 3;
    localparam int W      = CTRL_W + DATA_W;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic              out_flushed;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  bubble_cnt;

    int checks = 0;
    int passed = 0;

    // Reference model: items held in arrival order, front is what the stage presents.
    logic [W-1:0]      exp_q[$];
    logic              exp_flushed;
    logic [DATA_W-1:0] exp_data;
    logic [CNT_W-1:0]  exp_bubble;

    pipe_stage_reg #(
        .DATA_W(DATA_W),
        .CTRL_W(CTRL_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctrl    (in_ctrl),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ctrl   (out_ctrl),
        .out_data   (out_data),
        .out_flushed(out_flushed),
        .occupancy  (occupancy),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic exp_valid();
        return exp_q.size() > 0;
    endfunction

    function automatic logic [CTRL_W-1:0] exp_ctrl();
        logic [W-1:0] head;
        if (exp_q.size() == 0) return '0;
        head = exp_q[0];
        return head[W-1:DATA_W];
    endfunction

    function automatic logic [1:0] exp_occ();
        return 2'(exp_q.size());
    endfunction

    task automatic model_reset();
        exp_q.delete();
        exp_flushed = 1'b0;
        exp_data    = '0;
        exp_bubble  = '0;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drives one cycle, advances the model across the edge and returns in_ready seen before it.
    task automatic cycle(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                         input logic ordy, input logic fl,
                         output logic rdy_dut, output logic rdy_exp);
        int           sz;
        logic         fire;
        logic [W-1:0] head;
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        rdy_dut = in_ready;
        sz      = exp_q.size();
        rdy_exp = (CAP == 1) ? (sz == 0 || ordy) : (sz < 2);
        fire    = (sz > 0) && ordy;
        if (ordy && sz == 0 && exp_bubble != '1) exp_bubble = exp_bubble + 3'd1;
        if (fl) begin
            exp_q.delete();
            exp_flushed = 1'b1;
        end else begin
            if (fire) void'(exp_q.pop_front());
            if (v && rdy_exp) exp_q.push_back({c, d});
            if ((fire || sz == 0) && exp_q.size() > 0) begin
                head        = exp_q[0];
                exp_flushed = 1'b0;
                exp_data    = head[DATA_W-1:0];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
        checks++; if (out_ctrl !== 8'h00) $display("FAIL reset_out_ctrl: got %h expected 00", out_ctrl); else passed++;
        checks++; if (out_data !== 64'h0) $display("FAIL reset_out_data: got %h expected 0", out_data); else passed++;
        checks++; if (out_flushed !== 1'b0) $display("FAIL reset_out_flushed: got %b expected 0", out_flushed); else passed++;
        checks++; if (occupancy !== 2'd0) $display("FAIL reset_occupancy: got %0d expected 0", occupancy); else passed++;
        checks++; if (bubble_cnt !== 3'd0) $display("FAIL reset_bubble_cnt: got %0d expected 0", bubble_cnt); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic rd, re;
        cycle(1'b1, 8'hA5, 64'h1234, 1'b1, 1'b0, rd, re);
        checks++; if (rd !== 1'b1) $display("FAIL basic_in_ready: got %b expected 1", rd); else passed++;
        checks++; if (out_valid !== 1'b1) $display("FAIL basic_out_valid: got %b expected 1", out_valid); else passed++;
        checks++; if (out_ctrl !== 8'hA5) $display("FAIL basic_out_ctrl: got %h expected a5", out_ctrl); else passed++;
        checks++; if (out_data !== 64'h1234) $display("FAIL basic_out_data: got %h expected 1234", out_data); else passed++;
        checks++; if (occupancy !== 2'd1) $display("FAIL basic_occupancy: got %0d expected 1", occupancy); else passed++;
        cycle(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, rd, re);
        checks++; if (out_ctrl !== 8'h00) $display("FAIL basic_bubble_ctrl: got %h expected 00", out_ctrl); else passed++;
        checks++; if (out_data !== 64'h1234) $display("FAIL basic_hold_data: got %h expected 1234", out_data); else passed++;
    endtask

    task automatic test_backpressure();
        logic rd, re;
        cycle(1'b1, 8'h11, 64'hAAAA, 1'b1, 1'b0, rd, re);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 8'h22, 64'hBBBB, 1'b0, 1'b0, rd, re);
            checks++; if (rd !== re) $display("FAIL bp_in_ready[%0d]: got %b expected %b", i, rd, re); else passed++;
            checks++; if (out_data !== 64'hAAAA) $display("FAIL bp_hold_data[%0d]: got %h expected aaaa", i, out_data); else passed++;
            checks++; if (out_ctrl !== 8'h11) $display("FAIL bp_hold_ctrl[%0d]: got %h expected 11", i, out_ctrl); else passed++;
        end
        checks++; if (occupancy !== 2'(CAP)) $display("FAIL bp_occupancy: got %0d expected %0d", occupancy, CAP); else passed++;
        checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_stalled: got %b expected 0", in_ready); else passed++;
        cycle(1'b1, 8'h22, 64'hBBBB, 1'b1, 1'b0, rd, re);
        checks++; if (out_data !== 64'hBBBB) $display("FAIL bp_release_data: got %h expected bbbb", out_data); else passed++;
        checks++; if (out_valid !== 1'b1) $display("FAIL bp_release_valid: got %b expected 1", out_valid); else passed++;
        cycle(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, rd, re);
        checks++; if (out_valid !== 1'b0) $display("FAIL bp_drained: got %b expected 0", out_valid); else passed++;
    endtask

    task automatic test_flush();
        logic rd, re;
        cycle(1'b1, 8'h33, 64'hCAFE, 1'b1, 1'b0, rd, re);
        cycle(1'b1, 8'h44, 64'hBEEF, 1'b0, 1'b0, rd, re);
        checks++; if (occupancy !== 2'(CAP)) $display("FAIL flush_pre_occ: got %0d expected %0d", occupancy, CAP); else passed++;
        cycle(1'b1, 8'h55, 64'hDEAD, 1'b0, 1'b1, rd, re);
        checks++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid: got %b expected 0", out_valid); else passed++;
        checks++; if (out_ctrl !== 8'h00) $display("FAIL flush_out_ctrl: got %h expected 00", out_ctrl); else passed++;
        checks++; if (out_flushed !== 1'b1) $display("FAIL flush_flag_set: got %b expected 1", out_flushed); else passed++;
        checks++; if (occupancy !== 2'd0) $display("FAIL flush_occupancy: got %0d expected 0", occupancy); else passed++;
        checks++; if (out_data !== 64'hCAFE) $display("FAIL flush_data_hold: got %h expected cafe", out_data); else passed++;
        cycle(1'b1, 8'h66, 64'hF00D, 1'b1, 1'b0, rd, re);
        checks++; if (out_flushed !== 1'b0) $display("FAIL flush_flag_clear: got %b expected 0", out_flushed); else passed++;
        checks++; if (out_data !== 64'hF00D) $display("FAIL flush_next_data: got %h expected f00d", out_data); else passed++;
        checks++; if (occupancy !== 2'd1) $display("FAIL flush_next_occ: got %0d expected 1", occupancy); else passed++;
        cycle(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, rd, re);
    endtask

    task automatic test_async_reset();
        logic rd, re;
        cycle(1'b1, 8'h71, 64'h7001, 1'b1, 1'b0, rd, re);
        cycle(1'b1, 8'h72, 64'h7002, 1'b1, 1'b0, rd, re);
        cycle(1'b1, 8'h73, 64'h7003, 1'b0, 1'b0, rd, re);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL arst_out_valid: got %b expected 0", out_valid); else passed++;
        checks++; if (out_ctrl !== 8'h00) $display("FAIL arst_out_ctrl: got %h expected 00", out_ctrl); else passed++;
        checks++; if (out_data !== 64'h0) $display("FAIL arst_out_data: got %h expected 0", out_data); else passed++;
        checks++; if (occupancy !== 2'd0) $display("FAIL arst_occupancy: got %0d expected 0", occupancy); else passed++;
        checks++; if (bubble_cnt !== 3'd0) $display("FAIL arst_bubble_cnt: got %0d expected 0", bubble_cnt); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL arst_in_ready: got %b expected 1", in_ready); else passed++;
        #2;
        rst_n = 1'b1;
        model_reset();
        cycle(1'b1, 8'h7E, 64'h7EEE, 1'b1, 1'b0, rd, re);
        checks++; if (out_valid !== 1'b1) $display("FAIL arst_restart_valid: got %b expected 1", out_valid); else passed++;
        checks++; if (out_data !== 64'h7EEE) $display("FAIL arst_restart_data: got %h expected 7eee", out_data); else passed++;
        checks++; if (bubble_cnt !== exp_bubble) $display("FAIL arst_restart_bubble: got %0d expected %0d", bubble_cnt, exp_bubble); else passed++;
    endtask

    task automatic test_starve();
        logic rd, re;
        apply_reset();
        repeat (5) cycle(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, rd, re);
        checks++; if (bubble_cnt !== 3'd5) $display("FAIL starve_count5: got %0d expected 5", bubble_cnt); else passed++;
        repeat (5) cycle(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, rd, re);
        checks++; if (bubble_cnt !== 3'd7) $display("FAIL starve_saturate: got %0d expected 7", bubble_cnt); else passed++;
        cycle(1'b0, 8'h00, 64'h0, 1'b1, 1'b1, rd, re);
        checks++; if (bubble_cnt !== 3'd7) $display("FAIL starve_flush_keeps: got %0d expected 7", bubble_cnt); else passed++;
    endtask

    task automatic test_random();
        logic              rd, re, v, ordy, fl;
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            v    = 1'($urandom_range(0, 3) != 0);
            ordy = 1'($urandom_range(0, 2) != 0);
            fl   = 1'($urandom_range(0, 19) == 0);
            c    = 8'($urandom);
            d    = {$urandom, $urandom};
            cycle(v, c, d, ordy, fl, rd, re);
            checks++; if (rd !== re) $display("FAIL rand_in_ready[%0d]: got %b expected %b", i, rd, re); else passed++;
            checks++; if (out_valid !== exp_valid()) $display("FAIL rand_out_valid[%0d]: got %b expected %b", i, out_valid, exp_valid()); else passed++;
            checks++; if (out_ctrl !== exp_ctrl()) $display("FAIL rand_out_ctrl[%0d]: got %h expected %h", i, out_ctrl, exp_ctrl()); else passed++;
            checks++; if (out_data !== exp_data) $display("FAIL rand_out_data[%0d]: got %h expected %h", i, out_data, exp_data); else passed++;
            checks++; if (out_flushed !== exp_flushed) $display("FAIL rand_out_flushed[%0d]: got %b expected %b", i, out_flushed, exp_flushed); else passed++;
            checks++; if (occupancy !== exp_occ()) $display("FAIL rand_occupancy[%0d]: got %0d expected %0d", i, occupancy, exp_occ()); else passed++;
            checks++; if (bubble_cnt !== exp_bubble) $display("FAIL rand_bubble_cnt[%0d]: got %0d expected %0d", i, bubble_cnt, exp_bubble); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_starve();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, handshaked pipeline stage register that replaces the fixed per-stage register modules (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable slice. It uses a valid/ready handshake instead of separate upstream and downstream stall inputs. Killable control bits are zeroed whenever the stage holds a bubble, and a flush squashes all held entries. An optional skid buffer gives full throughput with a registered `in_ready`. One instance sits between each pair of pipeline stages.

## Interface
- `DATA_W`, default 64: width of the data payload (PC, operands, immediates); value held while the stage is empty.
- `CTRL_W`, default 8: width of the killable control payload (RegWrite, MemRead, MemWrite, ALUOp, ...); forced to 0 while the stage is empty.
- `CNT_W`, default 16: width of the bubble counter.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `flush` in 1: squash everything held in the stage and drop the current input.
- `in_valid` in 1: upstream offers an item.
- `in_ready` out 1: stage can accept; a transfer happens when `in_valid & in_ready`.
- `in_ctrl` in CTRL_W: killable control bits.
- `in_data` in DATA_W: payload.
- `out_valid` out 1: stage presents an item.
- `out_ready` in 1: downstream accepts; a transfer happens when `out_valid & out_ready`.
- `out_ctrl` out CTRL_W: held control; equals 0 whenever `out_valid = 0`.
- `out_data` out DATA_W: held payload; keeps its last value when empty.
- `out_flushed` out 1: the current bubble was produced by a flush.
- `occupancy` out 2: number of valid entries (0..1, or 0..2 with the skid buffer).
- `bubble_cnt` out CNT_W: saturating count of starved cycles.

## Operation
- Reset (`rst_n = 0`, takes effect asynchronously) drives:
  - `out_valid = 0`, `out_ctrl = 0`, `out_data = 0`, `out_flushed = 0`;
  - `occupancy = 0`, `bubble_cnt = 0`, `in_ready = 1`;
  - skid entry invalid, skid data 0.
- Accept path (main register empty, or emptying this cycle): the input loads into the main register.
- Hold path (`out_valid & !out_ready`): main register unchanged; this is the stall equivalent.
- `out_ctrl = main_ctrl & {CTRL_W{out_valid}}`. Control bits are also stored as 0 on any non-accepting cycle, so a bubble can never carry write enables.
- Flush, at a clock edge with `flush = 1`:
  - all entries become invalid; the input is not captured even if `in_valid & in_ready`;
  - `out_flushed` sets to 1;
  - data registers hold their values.
- `out_flushed` clears on the first edge that loads a valid item into the main register.
- Flush and a downstream transfer in the same cycle: the transfer completes (downstream owns it), then the stage empties.
- `bubble_cnt` increments on each edge where `out_ready & !out_valid`, saturating at `2^CNT_W - 1`. A flush does not clear it; only reset does.
- `occupancy` always reflects the registered entry valids.

## Timing
- Latency: an item accepted at edge N appears on `out_*` after edge N, i.e. one cycle.
- Throughput: one item per cycle in both modes while `out_ready = 1`.
- `out_valid`, `out_ctrl`, `out_data` and `out_flushed` are all registered; none is combinational from inputs.
- Without the skid buffer, `in_ready = !out_valid | out_ready`, which is combinational from `out_ready`.
- With the skid buffer, `in_ready = !skid_valid`, which is registered.
- Reset asserted mid-transfer: the item is lost, and all outputs take their reset values immediately.

## Configuration
- `PIPE_STAGE_SKID_EN` defined:
  - a second (skid) entry is added;
  - if the main register is full and `out_ready = 0` while `in_ready = 1`, the input goes to the skid entry;
  - when the main register empties, the skid entry moves into it (FIFO order);
  - `occupancy` ranges 0..2.
- `PIPE_STAGE_SKID_EN` undefined: single entry, combinational `in_ready`, `occupancy` ranges 0..1.
- Flush clears both entries.

## Structure
- The shared package `cpu_pipe_pkg` holds:
  - the default widths;
  - the per-boundary `CTRL_W`/`DATA_W` constants (IFID, IDEX, EXMEM, MEMWB);
  - the packing order of control bits.
- Sub-module `pipe_skid_buf` holds the optional skid entry and its valid bit. It is instantiated only under `PIPE_STAGE_SKID_EN`.

## Test plan
- Reset release, then `in_valid = 1`, `in_ctrl = 8'hA5`, `in_data = 64'h1234`, `out_ready = 1` for one edge -> next cycle `out_valid = 1`, `out_ctrl = 8'hA5`, `out_data = 64'h1234`, `occupancy = 1`.
- Backpressure: load item A, `out_ready = 0` for 3 cycles while offering B ->
  - `out_data` stays A;
  - skid mode: B sits in the skid entry, `occupancy = 2`, `in_ready = 0`;
  - on release, A then B appear on consecutive cycles.
- Flush with 2 entries valid and `in_valid = 1` -> next cycle `out_valid = 0`, `out_ctrl = 0`, `out_flushed = 1`, `occupancy = 0`; the input is dropped; `out_flushed` clears after the next accepted item.
- Starvation: `out_ready = 1`, `in_valid = 0` for 5 cycles with `CNT_W = 3` -> `bubble_cnt = 5`; after 10 cycles it saturates at 7.
- Async reset pulse mid-stream (`rst_n` low between edges) -> outputs return to their reset values before the next edge; the stream restarts cleanly after release.
